// File: rtl/sd_dat_block_rx.sv
// sd_dat_block_rx: receive controller for one SD data block on DAT0.
// Waits for the start bit and enables the external DAT shift register
// during the data phase. Strobes out each assembled byte, then checks
// the trailing CRC16-CCITT and the end bit, and reports the result.
// All state updates on the falling clock edge, which is the same edge
// the shift register uses to sample DAT0.
module sd_dat_block_rx #(
  parameter int BLOCK_BYTES  = 512,
  parameter int TIMEOUT_CLKS = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sdatain,
  input  logic [7:0] DATASI,
  output logic       oe,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       busy,
  output logic       done,
  output logic       crc_err,
  output logic       end_err,
  output logic       timeout
);

  localparam int BYTE_W = $clog2(BLOCK_BYTES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    DATA,
    CRC,
    ENDBIT,
    FINISH
  } state_t;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [3:0]        crc_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [15:0]       crc;
  logic [15:0]       crc_next;
  logic              crc_fb;
  logic              unused_datasi_msb;

  // The oldest shift register bit drops out as the last data bit enters.
  assign unused_datasi_msb = DATASI[7];

  // The shift register only captures while the FSM is in the data phase.
  assign oe = (state != DATA);

  // Serial CRC16-CCITT step for the data bit on DAT0 this edge.
  always_comb begin
    crc_fb   = sdatain ^ crc[15];
    crc_next = {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
  end

  // Block receive FSM with its counters, CRC register and registered outputs.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      crc_cnt    <= 4'd0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      crc        <= 16'h0000;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      crc_err    <= 1'b0;
      end_err    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            state    <= WAIT_START;
            busy     <= 1'b1;
            crc_err  <= 1'b0;
            end_err  <= 1'b0;
            timeout  <= 1'b0;
            crc      <= 16'h0000;
            bit_cnt  <= 3'd0;
            crc_cnt  <= 4'd0;
            byte_cnt <= '0;
            to_cnt   <= '0;
          end
        end
        WAIT_START: begin
          if (!sdatain) begin
            state <= DATA;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
              timeout <= 1'b1;
              state   <= FINISH;
            end
          end
        end
        DATA: begin
          crc     <= crc_next;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_data  <= {DATASI[6:0], sdatain};
            byte_valid <= 1'b1;
            byte_cnt   <= byte_cnt + 1'b1;
            if (byte_cnt == BYTE_W'(BLOCK_BYTES - 1)) begin
              state   <= CRC;
              bit_cnt <= 3'd0;
            end
          end
        end
        CRC: begin
          if (sdatain != crc[15]) begin
            crc_err <= 1'b1;
          end
          crc     <= {crc[14:0], 1'b0};
          crc_cnt <= crc_cnt + 4'd1;
          if (crc_cnt == 4'd15) begin
            state <= ENDBIT;
          end
        end
        ENDBIT: begin
          if (!sdatain) begin
            end_err <= 1'b1;
          end
          state <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_block_rx.sv
// tb_sd_dat_block_rx: randomized self-checking bench for sd_dat_block_rx.
// Expected outputs for every cycle are derived from edge positions relative
// to the start bit and from a byte-wise CRC16 model.
module tb_sd_dat_block_rx;

  localparam int N_A = 512;
  localparam int N_B = 2;
  localparam int T   = 10;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic sdatain;
  logic sel;

  logic [7:0] shreg_a = 8'h00;
  logic [7:0] shreg_b = 8'h00;

  logic       oe_a, bv_a, busy_a, done_a, crc_a, end_a, to_a;
  logic       oe_b, bv_b, busy_b, done_b, crc_b, end_b, to_b;
  logic [7:0] bd_a, bd_b;

  logic       oe_m, bv_m, busy_m, done_m, crc_m, end_m, to_m;
  logic [7:0] bd_m, datasi_m;

  logic       chk_en;
  logic       exp_oe, exp_bv, exp_busy, exp_done, exp_crc, exp_end, exp_to;
  logic [7:0] exp_bd;
  logic [7:0] prev_bd;

  int n_cmp;
  int n_bad;
  int oe_low_cnt;
  int bv_cnt;

  always #5 clk = ~clk;

  sd_dat_block_rx #(.BLOCK_BYTES(N_A), .TIMEOUT_CLKS(T)) dut_a (
    .clk(clk), .reset(reset), .start(start), .sdatain(sdatain),
    .DATASI(shreg_a), .oe(oe_a), .byte_data(bd_a), .byte_valid(bv_a),
    .busy(busy_a), .done(done_a), .crc_err(crc_a), .end_err(end_a),
    .timeout(to_a)
  );

  sd_dat_block_rx #(.BLOCK_BYTES(N_B), .TIMEOUT_CLKS(T)) dut_b (
    .clk(clk), .reset(reset), .start(start), .sdatain(sdatain),
    .DATASI(shreg_b), .oe(oe_b), .byte_data(bd_b), .byte_valid(bv_b),
    .busy(busy_b), .done(done_b), .crc_err(crc_b), .end_err(end_b),
    .timeout(to_b)
  );

  // Models of the external DAT shift registers, enabled by each DUT's oe.
  always @(negedge clk) begin
    if (!oe_a) shreg_a <= {shreg_a[6:0], sdatain};
    if (!oe_b) shreg_b <= {shreg_b[6:0], sdatain};
  end

  // Select which instance is being checked.
  always_comb begin
    oe_m     = sel ? oe_b   : oe_a;
    bv_m     = sel ? bv_b   : bv_a;
    busy_m   = sel ? busy_b : busy_a;
    done_m   = sel ? done_b : done_a;
    crc_m    = sel ? crc_b  : crc_a;
    end_m    = sel ? end_b  : end_a;
    to_m     = sel ? to_b   : to_a;
    bd_m     = sel ? bd_b   : bd_a;
    datasi_m = sel ? shreg_b : shreg_a;
  end

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
    end
  endtask

  // Per-cycle comparison of the checked DUT against the model expectations.
  always @(posedge clk) begin
    if (chk_en) begin
      check_output("oe",         {15'd0, oe_m},   {15'd0, exp_oe});
      check_output("byte_valid", {15'd0, bv_m},   {15'd0, exp_bv});
      check_output("byte_data",  {8'd0, bd_m},    {8'd0, exp_bd});
      check_output("busy",       {15'd0, busy_m}, {15'd0, exp_busy});
      check_output("done",       {15'd0, done_m}, {15'd0, exp_done});
      check_output("crc_err",    {15'd0, crc_m},  {15'd0, exp_crc});
      check_output("end_err",    {15'd0, end_m},  {15'd0, exp_end});
      check_output("timeout",    {15'd0, to_m},   {15'd0, exp_to});
      if (bv_m) check_output("byte_vs_DATASI", {8'd0, bd_m}, {8'd0, datasi_m});
      if (!oe_m) oe_low_cnt++;
      if (bv_m) bv_cnt++;
    end
  end

  function automatic logic [15:0] crc_of(input logic [7:0] data[$]);
    logic [15:0] c;
    c = 16'h0000;
    foreach (data[k]) begin
      c = c ^ {data[k], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic stream_bit(input int e, input int n, input int pre,
                                      input logic [7:0] data[$], input logic [15:0] cval,
                                      input logic endbit);
    int d;
    int i;
    logic [7:0] b;
    d = e - (pre + 1);
    if (e == 0 || pre >= T || d < 0) return 1'b1;
    if (d == 0) return 1'b0;
    if (d <= 8 * n) begin
      i = d - 1;
      b = data[i / 8];
      return b[7 - (i % 8)];
    end
    if (d <= 8 * n + 16) return cval[16 - (d - 8 * n)];
    if (d == 8 * n + 17) return endbit;
    return 1'b1;
  endfunction

  function automatic void set_reset_exp();
    exp_oe = 1'b1; exp_bv = 1'b0; exp_bd = 8'h00; exp_busy = 1'b0;
    exp_done = 1'b0; exp_crc = 1'b0; exp_end = 1'b0; exp_to = 1'b0;
    prev_bd = 8'h00;
  endfunction

  function automatic void rand_block(input int n, output logic [7:0] q[$]);
    q = {};
    for (int k = 0; k < n; k++) q.push_back(8'($urandom_range(0, 255)));
  endfunction

  // Drives one request (start pulse, optional idle bits, stream) and updates
  // the expectations edge by edge. Must be entered 1 time unit after a falling edge.
  task automatic apply_stimulus(input int n, input int pre, input logic [7:0] data[$],
                                input logic [15:0] cval, input logic endbit,
                                input int abort_edge, input int ign_edge);
    int s;
    int len;
    int d;
    int j;
    logic tmo;
    logic bad_upto;
    logic [15:0] good;
    good     = crc_of(data);
    tmo      = (pre >= T);
    s        = pre + 1;
    len      = tmo ? T + 3 : s + 8 * n + 20;
    bad_upto = 1'b0;
    for (int e = 0; e <= len; e++) begin
      if (e == abort_edge) begin
        reset = 1'b1;
        start = 1'b0;
        #1;
        check_output("abort_oe",   {15'd0, oe_m},   16'd1);
        check_output("abort_busy", {15'd0, busy_m}, 16'd0);
        check_output("abort_data", {8'd0, bd_m},    16'd0);
        set_reset_exp();
        @(negedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        return;
      end
      start   = (e == 0) || (e == ign_edge);
      sdatain = stream_bit(e, n, pre, data, cval, endbit);
      @(negedge clk); #1;
      start = 1'b0;
      if (tmo) begin
        exp_oe = 1'b1; exp_bv = 1'b0; exp_bd = prev_bd;
        exp_busy = (e <= T + 1); exp_done = (e == T + 1);
        exp_to = (e >= T); exp_crc = 1'b0; exp_end = 1'b0;
      end else begin
        d = e - s;
        exp_busy = (d <= 8 * n + 18);
        exp_oe   = !(d >= 0 && d <= 8 * n - 1);
        exp_bv   = (d >= 8 && d <= 8 * n && (d % 8) == 0);
        if (exp_bv) prev_bd = data[d / 8 - 1];
        exp_bd   = prev_bd;
        exp_done = (d == 8 * n + 18);
        if (d >= 8 * n + 1 && d <= 8 * n + 16) begin
          j = d - 8 * n;
          if (cval[16 - j] != good[16 - j]) bad_upto = 1'b1;
        end
        exp_crc = bad_upto;
        exp_end = (d >= 8 * n + 17) && !endbit;
        exp_to  = 1'b0;
      end
    end
  endtask

  // Bounded run time: report and stop if the sequence never completes.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Main test sequence.
  initial begin
    logic [7:0] ff[$];
    logic [7:0] q[$];
    logic [15:0] cv;
    int pre;
    n_cmp = 0; n_bad = 0; oe_low_cnt = 0; bv_cnt = 0;
    sel = 1'b0; chk_en = 1'b0;
    reset = 1'b1; start = 1'b0; sdatain = 1'b1;
    set_reset_exp();
    repeat (2) @(negedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;

    ff = {};
    for (int k = 0; k < N_A; k++) ff.push_back(8'hFF);
    check_output("crc_model_512xFF", crc_of(ff), 16'h7FA1);

    $display("[TB] good block of 0xFF");
    oe_low_cnt = 0; bv_cnt = 0;
    apply_stimulus(N_A, 3, ff, 16'h7FA1, 1'b1, -1, -1);
    check_output("oe_low_cycles", 16'(oe_low_cnt), 16'd4096);
    check_output("strobe_count",  16'(bv_cnt),     16'd512);
    check_output("good_crc_err",  {15'd0, crc_a},  16'd0);

    $display("[TB] bad CRC 7FA0");
    apply_stimulus(N_A, 0, ff, 16'h7FA0, 1'b1, -1, -1);
    check_output("bad_crc_flag", {15'd0, crc_a}, 16'd1);

    $display("[TB] random block with end bit 0");
    rand_block(N_A, q);
    apply_stimulus(N_A, 5, q, crc_of(q), 1'b0, -1, -1);
    check_output("end_err_flag", {15'd0, end_a}, 16'd1);

    $display("[TB] timeout");
    oe_low_cnt = 0; bv_cnt = 0;
    apply_stimulus(N_A, T + 5, q, 16'h0000, 1'b1, -1, -1);
    check_output("timeout_oe_low", 16'(oe_low_cnt), 16'd0);
    check_output("timeout_strobes", 16'(bv_cnt), 16'd0);
    check_output("timeout_flag", {15'd0, to_a}, 16'd1);

    $display("[TB] reset during byte 100, then clean block with ignored start");
    pre = $urandom_range(0, T - 1);
    rand_block(N_A, q);
    apply_stimulus(N_A, pre, q, crc_of(q), 1'b1, pre + 1 + 8 * 100 + 3, -1);
    rand_block(N_A, q);
    apply_stimulus(N_A, T - 1, q, crc_of(q), 1'b1, -1, T + 40);

    $display("[TB] two-byte blocks");
    reset = 1'b1;
    set_reset_exp();
    @(negedge clk); #1;
    reset = 1'b0;
    sel = 1'b1;
    @(negedge clk); #1;
    q = {8'hA5, 8'h3C};
    apply_stimulus(N_B, 2, q, crc_of(q), 1'b1, -1, -1);
    check_output("last_byte_3C", {8'd0, bd_b}, 16'h003C);
    for (int r = 0; r < 12; r++) begin
      rand_block(N_B, q);
      cv = crc_of(q);
      if ($urandom_range(0, 2) == 0) cv = cv ^ (16'h0001 << $urandom_range(0, 15));
      apply_stimulus(N_B, $urandom_range(0, T + 2), q, cv, 1'($urandom_range(0, 3) != 0), -1, -1);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_dat_block_rx.md
Name: sd_dat_block_rx

Overview:
- Block-level receive controller for the SD card DAT0 line, directly downstream of the DAT serial shift register.
- Waits for the start bit and drives the shift register's active-low output enable during the data phase.
- Emits each assembled byte with a strobe, then checks the trailing CRC16 and end bit.
- Reports done, CRC error, end-bit error and start-bit timeout to the command/read sequencer.

Parameters:
- BLOCK_BYTES, 512: data bytes per block (1..4096).
- TIMEOUT_CLKS, 65535: clk cycles allowed in WAIT_START before timeout (>=2).

Ports:
- clk  input  1  SD clock. All registers update on the falling edge, aligned with the shift register's DAT0 sampling edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle request to arm reception; ignored while busy=1.
- sdatain  input  1  DAT0 line, same net that feeds the shift register.
- DATASI  input  8  parallel output of the DAT shift register.
- oe  output  1  shift register output enable, active-low; 0 only in DATA.
- byte_data  output  8  last completed data byte.
- byte_valid  output  1  one-cycle strobe, byte_data is new.
- busy  output  1  1 in every state except IDLE.
- done  output  1  one-cycle pulse on block end (good, error or timeout).
- crc_err  output  1  sticky CRC mismatch flag for the last block.
- end_err  output  1  sticky flag: end bit sampled as 0.
- timeout  output  1  sticky flag: no start bit within TIMEOUT_CLKS.

Behaviour:
- Reset values:
  - state=IDLE; oe=1; byte_data=8'h00.
  - byte_valid, busy, done, crc_err, end_err, timeout all 0.
  - All counters 0; CRC register 16'h0000.
- States: IDLE, WAIT_START, DATA, CRC, ENDBIT, FINISH.
- IDLE -> WAIT_START on start=1.
  - Clears crc_err, end_err, timeout, CRC register, bit/byte counters, timeout counter.
- WAIT_START:
  - Each edge with sdatain=1 increments the timeout counter.
  - sdatain=0 (start bit) -> DATA. The start bit is not shifted and not CRC'd.
  - If the counter reaches TIMEOUT_CLKS-1 with sdatain=1: set timeout=1 and go to FINISH.
  - If a start bit arrives on that same edge, the start bit wins.
- oe = 0 exactly while state==DATA (decoded from registered state). The shift register therefore captures only data bits, MSB first.
- DATA:
  - Every edge advances a 3-bit bit counter and feeds sdatain into the CRC.
  - CRC is CRC16-CCITT (x^16+x^12+x^5+1), serial, init 0: fb = sdatain ^ crc[15]; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - On the edge of bit counter=7:
    - byte_data <= {DATASI[6:0], sdatain}, i.e. the value the shift register holds after that same edge.
    - byte_valid=1 for the following cycle.
    - Byte counter increments.
  - After byte BLOCK_BYTES-1 completes -> CRC, bit counter reset.
- CRC:
  - Every edge compares sdatain with crc[15]; the CRC register shifts left, filling 0.
  - Any mismatch sets crc_err.
  - After 16 edges -> ENDBIT.
- ENDBIT: sdatain=0 sets end_err; -> FINISH.
- FINISH: done=1 for one cycle; -> IDLE. busy falls on the same edge done falls.
- Sticky flags hold until the next accepted start or reset.
- Reset mid-operation: immediate return to reset values, oe=1, no done pulse.
- start asserted while busy=1: no effect, no restart.
- Latency with BLOCK_BYTES=N: done is asserted 8N+18 falling edges after the start-bit edge.

Test Plan:
- Reset, start, start bit, 512 x 8'hFF, CRC 16'h7FA1, end bit 1:
  - oe low for exactly 4096 edges.
  - 512 byte_valid strobes, each with byte_data=8'hFF.
  - done pulse; crc_err=0, end_err=0, timeout=0.
- Same stream with CRC sent as 16'h7FA0:
  - crc_err=1 at done, end_err=0.
  - crc_err clears on the next start.
- Same stream, end bit driven 0 → end_err=1, crc_err=0.
- TIMEOUT_CLKS=10, start, sdatain held 1:
  - done pulses with timeout=1 and no byte_valid.
  - oe never low.
- BLOCK_BYTES=2, bytes 8'hA5, 8'h3C:
  - byte_data shows A5 then 3C, matching DATASI one cycle after each strobe.
  - Compare CRC against the reference model.
- Assert reset during byte 100, then start a new block:
  - Outputs return to reset values immediately; oe=1.
  - Second block completes cleanly.
  - A start pulse during DATA is ignored.
